// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS down-counter driven by the shared 1 Hz tick, with a latched alarm at 00:00
//   clk        system clock, all state on posedge
//   reset      asynchronous active-high reset
//   tick       1-cycle 1 Hz enable
//   load       load preset (ignored while running)
//   load_min   preset minutes, clamped to MAX_MIN
//   load_sec   preset seconds, clamped to 59
//   start      begin/resume counting (only from a non-zero value)
//   pause      suspend counting
//   clear      abort to 00:00 / IDLE
//   ack        silence the alarm
//   min, sec   current value
//   running    high while counting
//   alarm      high while expired
//   done_pulse one-cycle pulse when 00:00 is reached
module countdown_timer #(
    parameter int MIN_W   = 7,
    parameter int SEC_W   = 6,
    parameter int MAX_MIN = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             ack,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] sec,
    output logic             running,
    output logic             alarm,
    output logic             done_pulse
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t           st_q, st_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             running_q, alarm_q, done_q, done_d;
    logic             zero_q;

    assign zero_q = (min_q == '0) && (sec_q == '0);

    // Commands that do not apply in the current state are treated as absent,
    // so a lower-priority command in the same cycle still takes effect.
    always_comb begin
        st_d   = st_q;
        min_d  = min_q;
        sec_d  = sec_q;
        done_d = 1'b0;
        if (clear) begin
            st_d  = IDLE;
            min_d = '0;
            sec_d = '0;
        end else if (load && st_q != RUN) begin
            min_d = (load_min > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : load_min;
            sec_d = (load_sec > SEC_W'(59)) ? SEC_W'(59) : load_sec;
            st_d  = (st_q == EXPIRED) ? IDLE : st_q;
        end else if (start && (st_q == IDLE || st_q == PAUSED) && !zero_q) begin
            st_d = RUN;
        end else if (pause && st_q == RUN) begin
            st_d = PAUSED;
        end else if (ack && st_q == EXPIRED) begin
            st_d = IDLE;
        end else if (tick && st_q == RUN) begin
            // RUN never holds 00:00, so the borrow branch always has min_q > 0
            sec_d = (sec_q != '0) ? sec_q - SEC_W'(1) : SEC_W'(59);
            min_d = (sec_q != '0) ? min_q : min_q - MIN_W'(1);
            if (min_d == '0 && sec_d == '0) begin
                st_d   = EXPIRED;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= (st_d == RUN);
            alarm_q   <= (st_d == EXPIRED);
            done_q    <= done_d;
        end
    end

    assign min        = min_q;
    assign sec        = sec_q;
    assign running    = running_q;
    assign alarm      = alarm_q;
    assign done_pulse = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random checks of countdown_timer against a total-seconds model
module tb_countdown_timer;
    localparam int MIN_W = 7, SEC_W = 6, MAX_MIN = 99;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAU = 2, M_EXP = 3;

    logic             clk = 1'b0;
    logic             reset, tick, load, start, pause, clear, ack;
    logic [MIN_W-1:0] load_min, min;
    logic [SEC_W-1:0] load_sec, sec;
    logic             running, alarm, done_pulse;

    int npass = 0, ntot = 0;
    int m_mode, m_tot, m_done;

    countdown_timer #(.MIN_W(MIN_W), .SEC_W(SEC_W), .MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .load_min(load_min),
        .load_sec(load_sec), .start(start), .pause(pause), .clear(clear), .ack(ack),
        .min(min), .sec(sec), .running(running), .alarm(alarm), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_tot  = 0;
        m_done = 0;
    endtask

    // Value kept as total remaining seconds; MM:SS is derived by division.
    task automatic model_step();
        int lm, ls;
        lm = int'(load_min) > MAX_MIN ? MAX_MIN : int'(load_min);
        ls = int'(load_sec) > 59 ? 59 : int'(load_sec);
        m_done = 0;
        if (clear) begin
            m_tot = 0;
            m_mode = M_IDLE;
        end else if (load && m_mode != M_RUN) begin
            m_tot = lm * 60 + ls;
            if (m_mode == M_EXP) m_mode = M_IDLE;
        end else if (start && (m_mode == M_IDLE || m_mode == M_PAU) && m_tot > 0) begin
            m_mode = M_RUN;
        end else if (pause && m_mode == M_RUN) begin
            m_mode = M_PAU;
        end else if (ack && m_mode == M_EXP) begin
            m_mode = M_IDLE;
        end else if (tick && m_mode == M_RUN) begin
            m_tot--;
            if (m_tot == 0) begin
                m_mode = M_EXP;
                m_done = 1;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".min"}, int'(min), m_tot / 60);
        chk({tag, ".sec"}, int'(sec), m_tot % 60);
        chk({tag, ".running"}, int'(running), int'(m_mode == M_RUN));
        chk({tag, ".alarm"}, int'(alarm), int'(m_mode == M_EXP));
        chk({tag, ".done"}, int'(done_pulse), m_done);
    endtask

    // Called at a falling edge: drive one cycle of inputs, predict, check at the next falling edge.
    task automatic cyc(input string tag, input logic t, input logic ld, input int lm, input int ls,
                       input logic s, input logic p, input logic c, input logic a);
        tick = t; load = ld; load_min = MIN_W'(lm); load_sec = SEC_W'(ls);
        start = s; pause = p; clear = c; ack = a;
        model_step();
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic async_rst(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outs({tag, ".imm"});
        @(negedge clk);
        check_outs({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {tick, load, start, pause, clear, ack} = '0;
        load_min = '0;
        load_sec = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs("reset");
        reset = 1'b0;

        // 00:03 to expiry
        cyc("t1_load", 0, 1, 0, 3, 0, 0, 0, 0);
        cyc("t1_start", 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t1_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_done", int'(done_pulse), 1);
        chk("t1_alarm", int'(alarm), 1);
        cyc("t1_after", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_done_gone", int'(done_pulse), 0);

        // borrow from 02:00 and full run down
        cyc("t2_load", 0, 1, 2, 0, 0, 0, 0, 0);
        cyc("t2_start", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("t2_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_borrow_min", int'(min), 1);
        chk("t2_borrow_sec", int'(sec), 59);
        for (int i = 0; i < 119; i++) cyc("t2_run", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_expired", int'(alarm), 1);

        // pause drops coincident tick
        cyc("t3_load", 0, 1, 0, 10, 0, 0, 0, 0);
        cyc("t3_start", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("t3_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_pause", 1, 0, 0, 0, 0, 1, 0, 0);
        chk("t3_hold_sec", int'(sec), 8);
        cyc("t3_frozen", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_resume", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("t3_tick2", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_sec7", int'(sec), 7);

        // clamping and zero-length start
        cyc("t4_clear", 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("t4_clamp", 0, 1, 120, 63, 0, 0, 0, 0);
        chk("t4_min99", int'(min), 99);
        chk("t4_sec59", int'(sec), 59);
        cyc("t4_load0", 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t4_start0", 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_not_running", int'(running), 0);

        // expired ignores ticks, ack returns to idle
        cyc("t5_load", 0, 1, 0, 1, 0, 0, 0, 0);
        cyc("t5_start", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("t5_expire", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("t5_tick", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_alarm_held", int'(alarm), 1);
        cyc("t5_ack", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t5_alarm_off", int'(alarm), 0);

        // async reset mid-run, load ignored in run, clear beats load
        cyc("t6_load", 0, 1, 5, 0, 0, 0, 0, 0);
        cyc("t6_start", 0, 0, 0, 0, 1, 0, 0, 0);
        async_rst("t6_rst");
        chk("t6_rst_min", int'(min), 0);
        cyc("t6_load2", 0, 1, 0, 5, 0, 0, 0, 0);
        cyc("t6_start2", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("t6_ld_in_run", 0, 1, 3, 0, 0, 0, 0, 0);
        chk("t6_ld_ignored", int'(sec), 5);
        cyc("t6_clr_ld", 1, 1, 4, 4, 0, 0, 1, 0);
        chk("t6_clr_idle", int'(running), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) async_rst("rnd_rst");
            else cyc("rnd",
                     $urandom_range(0, 9) < 4,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 63)),
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 49) == 0,
                     $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
